// File: rtl/register_file_2r1w.sv
// DEPTH x DATA_WIDTH register file with one byte-enabled write port
// and two registered, write-first read ports.
module register_file_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [ADDR_WIDTH-1:0]     wAddr,
    input  logic [DATA_WIDTH/8-1:0]   wBe,
    input  logic [DATA_WIDTH-1:0]     wData,
    input  logic [ADDR_WIDTH-1:0]     rAddrA,
    output logic [DATA_WIDTH-1:0]     rDataA,
    input  logic [ADDR_WIDTH-1:0]     rAddrB,
    output logic [DATA_WIDTH-1:0]     rDataB,
    output logic [2**ADDR_WIDTH-1:0]  written
);

    localparam int DEPTH  = 2**ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH/8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] mergedWord;
    logic [DATA_WIDTH-1:0] nextA;
    logic [DATA_WIDTH-1:0] nextB;
    logic                  wProt;
    logic                  wEff;
    logic                  fwdA;
    logic                  fwdB;
    logic                  zeroA;
    logic                  zeroB;

    // Post-write value of the addressed entry; also the forwarded word.
    always_comb begin
        mergedWord = mem[wAddr];
        for (int i = 0; i < NBYTES; i++) begin
            if (wBe[i]) begin
                mergedWord[8*i +: 8] = wData[8*i +: 8];
            end
        end
    end

    assign wProt = (ZERO_REG != 0) && (wAddr == '0);
    assign wEff  = we && (|wBe) && !wProt;
    assign fwdA  = we && !wProt && (rAddrA == wAddr);
    assign fwdB  = we && !wProt && (rAddrB == wAddr);
    assign zeroA = (ZERO_REG != 0) && (rAddrA == '0);
    assign zeroB = (ZERO_REG != 0) && (rAddrB == '0);

    // zeroX and fwdX are exclusive: forwarding needs an unprotected target.
    always_comb begin
        nextA = mem[rAddrA];
        unique case (1'b1)
            zeroA:   nextA = '0;
            fwdA:    nextA = mergedWord;
            default: nextA = mem[rAddrA];
        endcase
    end

    always_comb begin
        nextB = mem[rAddrB];
        unique case (1'b1)
            zeroB:   nextB = '0;
            fwdB:    nextB = mergedWord;
            default: nextB = mem[rAddrB];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            rDataA  <= '0;
            rDataB  <= '0;
            written <= '0;
        end else begin
            if (wEff) begin
                mem[wAddr]     <= mergedWord;
                written[wAddr] <= 1'b1;
            end
            rDataA <= nextA;
            rDataB <= nextB;
        end
    end

endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
- Parametrised successor to the 8x32 single-port register file.
- Provides one write port with byte enables and two independent registered read ports with write-first forwarding.
- Tracks a per-entry "written since reset" status vector.
- Serves as the operand store for the datapath blocks that need two source operands per cycle.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH entries.
- ZERO_REG, 0, when 1, entry 0 is hardwired to zero and ignores writes.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- wAddr  input  ADDR_WIDTH  write address.
- wBe  input  DATA_WIDTH/8  byte write enables; bit i covers wData[8i+7:8i].
- wData  input  DATA_WIDTH  write data.
- rAddrA  input  ADDR_WIDTH  read address, port A.
- rDataA  output  DATA_WIDTH  registered read data, port A.
- rAddrB  input  ADDR_WIDTH  read address, port B.
- rDataB  output  DATA_WIDTH  registered read data, port B.
- written  output  DEPTH  bit k = 1 once entry k has taken at least one effective write since reset.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. Polarity and synchronicity are fixed.
- Reset (reset = 1 at a rising edge):
  - All DEPTH entries, rDataA, rDataB and written are cleared to 0.
  - Reset dominates: a write or read presented in the same cycle is discarded.
  - Reset asserted mid-sequence loses all contents; the first read after reset release returns 0.
- Write:
  - On a rising edge with we = 1, for each i where wBe[i] = 1, entry[wAddr] byte i takes wData byte i. Other bytes hold.
  - we = 1 with wBe = 0 is a no-op: contents unchanged and written unchanged.
  - An effective write has we = 1, wBe != 0, and is not to a ZERO_REG-protected entry 0. It sets written[wAddr] at the same edge.
- ZERO_REG = 1:
  - Writes to entry 0 are ignored.
  - written[0] stays 0.
  - Reads of address 0 always return 0.
- Read:
  - Each port samples its rAddr at rising edge N and presents data on rDataX after edge N, so latency is 1 cycle.
  - rDataX holds until the next edge.
  - Ports A and B are fully independent and may read the same address.
- Write-first forwarding:
  - If we = 1 and rAddrX == wAddr at edge N, rDataX after edge N is the merged word.
  - Merged word = enabled bytes from wData, remaining bytes from the old entry. This equals the entry's post-write value.
  - Forwarding applies to both ports simultaneously.
  - Forwarding is suppressed for protected entry 0.
- Width rules:
  - No arithmetic is performed.
  - Addresses are full-range; every value 0..DEPTH-1 is valid, with no wrap or out-of-range case.
- There is no combinational path from any input to any output.

Test Plan:
- Reset/default:
  - Stimulus: reset = 1 for 2 cycles, then release. Read A = 3'd5, B = 3'd7.
  - Required: rDataA = rDataB = 0, written = 8'h00.
- Full-word writes and dual read:
  - Stimulus: write 32'h1111_1111 to addr 0, 32'h1FF1_FF11 to addr 1, 32'h1000_F011 to addr 5, 32'hEFEF_0101 to addr 7, all with wBe = 4'hF. Then A = 1, B = 7.
  - Required: next cycle rDataA = 32'h1FF1_FF11, rDataB = 32'hEFEF_0101, written = 8'hA3.
- Byte enables:
  - Stimulus: addr 5 holds 32'h1000_F011; write wData = 32'hAABB_CCDD, wBe = 4'b0101; then read addr 5.
  - Required: 32'h10BB_F0DD.
  - Stimulus: wBe = 4'b0000 to addr 2.
  - Required: written[2] stays 0.
- Write-first forwarding:
  - Stimulus: in one cycle, we = 1, wAddr = 3, wData = 32'hDEAD_BEEF, wBe = 4'b0011, rAddrA = rAddrB = 3, with entry 3 = 32'h1234_5678.
  - Required: after that edge rDataA = rDataB = 32'h1234_BEEF.
- ZERO_REG = 1 instance:
  - Stimulus: write 32'hFFFF_FFFF to addr 0 with a same-cycle read of addr 0.
  - Required: rDataA = 0, written[0] = 0.
  - Stimulus: the same write to addr 4.
  - Required: reads back 32'hFFFF_FFFF.
- Reset mid-operation:
  - Stimulus: assert reset in the same cycle as we = 1, wAddr = 6, wData = 32'h5555_5555.
  - Required: after release, addr 6 reads 0, written = 0, and rDataA = rDataB = 0 during reset.
